storage_responder: RTL and testbench

- Storage-side server for the per-core storage request path.
- Accepts 12-bit {core number, address} words that the arbitration winner writes in, and buffers them in an internal FIFO.
- Serves one entry at a time: issues a read to the 32-bit storage array, returns the data on a shared bus, and pulses the one-hot txn_done bit of the requesting core.

---
 rtl/storage_responder_if.sv | 25 ++
 rtl/storage_responder.sv | 127 ++++++++++++
 tb/tb_storage_responder.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/storage_responder_if.sv
// Request, storage-read and response signals of the storage responder.
// The master side is the requester/storage environment; the slave side is the responder.
interface storage_responder_if #(
  parameter int unsigned NUM_CORES = 4
);
  logic                 req_valid;
  logic [11:0]          req_number_and_addr;
  logic                 req_ready;
  logic                 mem_rd_en;
  logic [7:0]           mem_addr;
  logic [31:0]          mem_rd_data;
  logic [31:0]          rsp_data;
  logic [NUM_CORES-1:0] txn_done;
  logic [1:0]           err_flags;

  modport master (
    output req_valid, req_number_and_addr, mem_rd_data,
    input  req_ready, mem_rd_en, mem_addr, rsp_data, txn_done, err_flags
  );

  modport slave (
    input  req_valid, req_number_and_addr, mem_rd_data,
    output req_ready, mem_rd_en, mem_addr, rsp_data, txn_done, err_flags
  );
endinterface

// File: rtl/storage_responder.sv
// Storage-side server: buffers {core, addr} requests in a FIFO, reads the storage array one
// request at a time and signals completion with a one-hot pulse to the requesting core.
module storage_responder #(
  parameter int unsigned NUM_CORES   = 4,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned MEM_LATENCY = 1
) (
  input logic                clk,
  input logic                rst_n,
  storage_responder_if.slave bus
);

  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WaitW = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e               state_q, state_d;
  logic [11:0]          fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q, count_d;
  logic [3:0]           num_q, num_d;
  logic [WaitW-1:0]     wait_q, wait_d;
  logic                 rd_en_q, rd_en_d;
  logic [7:0]           mem_addr_q, mem_addr_d;
  logic [31:0]          rsp_q, rsp_d;
  logic [NUM_CORES-1:0] txn_q, txn_d;
  logic [1:0]           err_q, err_d;
  logic [11:0]          head;
  logic                 push, pop, bad_num;

  assign bus.req_ready = (count_q != CntW'(FIFO_DEPTH));
  assign push          = bus.req_valid && bus.req_ready;
  assign pop           = (state_q == StIdle) && (count_q != '0);
  assign head          = fifo_q[rd_ptr_q];
  assign bad_num       = (num_q == 4'd0) || (32'(num_q) > NUM_CORES);

  // Storage words need no reset; only the pointers and count define occupancy.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= bus.req_number_and_addr;
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    wait_d     = wait_q;
    rd_en_d    = 1'b0;
    mem_addr_d = mem_addr_q;
    rsp_d      = rsp_q;
    txn_d      = '0;
    err_d      = err_q;
    err_d[0]   = err_q[0] | (bus.req_valid & ~bus.req_ready);
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          num_d      = head[11:8];
          mem_addr_d = head[7:0];
          rd_en_d    = 1'b1;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        wait_d  = WaitW'(MEM_LATENCY);
        state_d = StWait;
      end
      StWait: begin
        wait_d = wait_q - WaitW'(1);
        if (wait_q == WaitW'(1)) begin
          rsp_d = bus.mem_rd_data;
          // An out-of-range core number matches no bit, so it never pulses txn_done.
          for (int unsigned i = 0; i < NUM_CORES; i++) begin
            txn_d[i] = (32'(num_q) == 32'(i + 1));
          end
          err_d[1] = err_q[1] | bad_num;
          state_d  = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      num_q      <= '0;
      wait_q     <= '0;
      rd_en_q    <= 1'b0;
      mem_addr_q <= '0;
      rsp_q      <= '0;
      txn_q      <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
      rd_ptr_q   <= pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
      count_q    <= count_d;
      num_q      <= num_d;
      wait_q     <= wait_d;
      rd_en_q    <= rd_en_d;
      mem_addr_q <= mem_addr_d;
      rsp_q      <= rsp_d;
      txn_q      <= txn_d;
      err_q      <= err_d;
    end
  end

  assign bus.mem_rd_en = rd_en_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.rsp_data  = rsp_q;
  assign bus.txn_done  = txn_q;
  assign bus.err_flags = err_q;

endmodule

// File: tb/tb_storage_responder.sv
// Bench for storage_responder: two instances (read latency 1 and 8) driven in lockstep and
// compared against a request-level timing model of service order and completion cycles.
module tb_storage_responder;

  localparam int unsigned NC    = 4;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid;
  logic [11:0] req_word;
  int unsigned cyc = 0;
  int          checks = 0;
  int          passes = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  storage_responder_if #(.NUM_CORES(NC)) bus1 ();
  storage_responder_if #(.NUM_CORES(NC)) bus8 ();

  storage_responder #(.NUM_CORES(NC), .FIFO_DEPTH(DEPTH), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );
  storage_responder #(.NUM_CORES(NC), .FIFO_DEPTH(DEPTH), .MEM_LATENCY(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8)
  );

  assign bus1.req_valid           = req_valid;
  assign bus1.req_number_and_addr = req_word;
  assign bus8.req_valid           = req_valid;
  assign bus8.req_number_and_addr = req_word;

  // Storage arrays: data appears exactly LAT edges after the read is sampled, junk otherwise.
  logic [31:0] tbl [256];
  logic [31:0] pipe1;
  logic [31:0] pipe8 [8];
  always @(posedge clk) pipe1 <= bus1.mem_rd_en ? tbl[bus1.mem_addr] : 32'h0BAD_0BAD;
  always @(posedge clk) begin
    pipe8[0] <= bus8.mem_rd_en ? tbl[bus8.mem_addr] : 32'h0BAD_0BAD;
    for (int i = 1; i < 8; i++) pipe8[i] <= pipe8[i-1];
  end
  assign bus1.mem_rd_data = pipe1;
  assign bus8.mem_rd_data = pipe8[7];

  logic        rdy [2];
  logic [1:0]  errf [2];
  logic [31:0] rsp [2];
  logic [3:0]  txn [2];
  logic        rden [2];
  logic [7:0]  maddr [2];
  assign rdy[0] = bus1.req_ready;   assign rdy[1] = bus8.req_ready;
  assign errf[0] = bus1.err_flags;  assign errf[1] = bus8.err_flags;
  assign rsp[0] = bus1.rsp_data;    assign rsp[1] = bus8.rsp_data;
  assign txn[0] = bus1.txn_done;    assign txn[1] = bus8.txn_done;
  assign rden[0] = bus1.mem_rd_en;  assign rden[1] = bus8.mem_rd_en;
  assign maddr[0] = bus1.mem_addr;  assign maddr[1] = bus8.mem_addr;

  // Observed event logs: {cycle, txn_done, rsp_data} and {cycle, mem_addr}.
  logic [51:0] obs_done [2][512];
  logic [23:0] obs_rd [2][512];
  int          n_obs_done [2] = '{0, 0};
  int          n_obs_rd [2] = '{0, 0};
  int          base_done [2];
  int          base_rd [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (txn[d] != 4'h0 && n_obs_done[d] < 512) begin
        obs_done[d][n_obs_done[d]] <= {cyc[15:0], txn[d], rsp[d]};
        n_obs_done[d] <= n_obs_done[d] + 1;
      end
      if (rden[d] && n_obs_rd[d] < 512) begin
        obs_rd[d][n_obs_rd[d]] <= {cyc[15:0], maddr[d]};
        n_obs_rd[d] <= n_obs_rd[d] + 1;
      end
    end
  end

  // Reference model: each accepted request is popped at the first edge after its push at
  // which the server is free (LAT+3 cycles after the previous pop) and completes LAT+1 later.
  int          m_pop [2][64];
  int          m_n [2];
  int          m_last [2];
  bit          m_ovf [2];
  bit          m_bad [2];
  logic [51:0] exp_done [2][64];
  logic [23:0] exp_rd [2][64];
  int          n_exp_done [2];
  int          n_exp_rd [2];

  function automatic int lat(int d);
    return (d == 0) ? 1 : 8;
  endfunction

  function automatic int model_cnt(int d, int c);
    int n = 0;
    for (int k = 0; k < m_n[d]; k++) if (m_pop[d][k] >= c) n++;
    return n;
  endfunction

  function automatic void model_push(int d, int c, logic [11:0] w);
    int pop;
    int num;
    if (model_cnt(d, c) >= int'(DEPTH) || m_n[d] >= 64) begin
      m_ovf[d] = 1'b1;
      return;
    end
    pop = (c + 1 > m_last[d] + lat(d) + 3) ? c + 1 : m_last[d] + lat(d) + 3;
    m_last[d] = pop;
    m_pop[d][m_n[d]] = pop;
    m_n[d]++;
    exp_rd[d][n_exp_rd[d]] = {16'(pop), w[7:0]};
    n_exp_rd[d]++;
    num = int'(w[11:8]);
    if (num >= 1 && num <= int'(NC)) begin
      exp_done[d][n_exp_done[d]] = {16'(pop + 1 + lat(d)), 4'(1 << (num - 1)), tbl[w[7:0]]};
      n_exp_done[d]++;
    end else begin
      m_bad[d] = 1'b1;
    end
  endfunction

  function automatic logic [63:0] sig_done(int d, bit obs);
    logic [63:0] s;
    logic [51:0] e;
    int          n;
    s = 64'h1;
    n = obs ? n_obs_done[d] - base_done[d] : n_exp_done[d];
    for (int i = 0; i < n; i++) begin
      e = obs ? obs_done[d][base_done[d] + i] : exp_done[d][i];
      s = {s[62:0], s[63]} ^ {12'h0, e} ^ (64'(i + 1) * 64'h9E37_79B9);
    end
    return s;
  endfunction

  function automatic logic [63:0] sig_rd(int d, bit obs);
    logic [63:0] s;
    logic [23:0] e;
    int          n;
    s = 64'h1;
    n = obs ? n_obs_rd[d] - base_rd[d] : n_exp_rd[d];
    for (int i = 0; i < n; i++) begin
      e = obs ? obs_rd[d][base_rd[d] + i] : exp_rd[d][i];
      s = {s[62:0], s[63]} ^ {40'h0, e} ^ (64'(i + 1) * 64'h9E37_79B9);
    end
    return s;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  task automatic push(logic [11:0] w);
    req_valid = 1'b1;
    req_word  = w;
    for (int d = 0; d < 2; d++) model_push(d, int'(cyc) + 1, w);
    step();
    req_valid = 1'b0;
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    rst_n     = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      m_n[d] = 0;
      m_last[d] = -100;
      m_ovf[d] = 1'b0;
      m_bad[d] = 1'b0;
      n_exp_done[d] = 0;
      n_exp_rd[d] = 0;
      base_done[d] = n_obs_done[d];
      base_rd[d] = n_obs_rd[d];
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int d = 0; d < 2; d++) begin
      checks += 6;
      if (rdy[d] !== 1'b1) $display("FAIL reset req_ready dut%0d got %b want 1", d, rdy[d]);
      else passes++;
      if (txn[d] !== 4'h0) $display("FAIL reset txn_done dut%0d got %h want 0", d, txn[d]);
      else passes++;
      if (rden[d] !== 1'b0) $display("FAIL reset mem_rd_en dut%0d got %b want 0", d, rden[d]);
      else passes++;
      if (maddr[d] !== 8'h0) $display("FAIL reset mem_addr dut%0d got %h want 0", d, maddr[d]);
      else passes++;
      if (rsp[d] !== 32'h0) $display("FAIL reset rsp_data dut%0d got %h want 0", d, rsp[d]);
      else passes++;
      if (errf[d] !== 2'b00) $display("FAIL reset err_flags dut%0d got %b want 00", d, errf[d]);
      else passes++;
    end
  endtask

  task automatic test_single();
    do_reset();
    push(12'h13C);
    step();
    checks += 2;
    if (rden[0] !== 1'b1) $display("FAIL single rd_en dut0 got %b want 1", rden[0]);
    else passes++;
    if (maddr[0] !== 8'h3C) $display("FAIL single mem_addr dut0 got %h want 3c", maddr[0]);
    else passes++;
    step();
    checks += 2;
    if (rden[0] !== 1'b0) $display("FAIL single rd_en_off dut0 got %b want 0", rden[0]);
    else passes++;
    if (txn[0] !== 4'h0) $display("FAIL single early_done dut0 got %h want 0", txn[0]);
    else passes++;
    step();
    checks += 2;
    if (txn[0] !== 4'b0001) $display("FAIL single txn_done dut0 got %b want 0001", txn[0]);
    else passes++;
    if (rsp[0] !== 32'hDEADBEEF) $display("FAIL single rsp_data dut0 got %h want deadbeef", rsp[0]);
    else passes++;
    step();
    checks++;
    if (txn[0] !== 4'h0) $display("FAIL single done_clear dut0 got %h want 0", txn[0]);
    else passes++;
    idle(20);
    for (int d = 0; d < 2; d++) begin
      checks += 3;
      if (sig_done(d, 1'b1) !== sig_done(d, 1'b0))
        $display("FAIL single done_log dut%0d got %h want %h", d, sig_done(d, 1'b1), sig_done(d, 1'b0));
      else passes++;
      if (sig_rd(d, 1'b1) !== sig_rd(d, 1'b0))
        $display("FAIL single rd_log dut%0d got %h want %h", d, sig_rd(d, 1'b1), sig_rd(d, 1'b0));
      else passes++;
      if (errf[d] !== 2'b00) $display("FAIL single err_flags dut%0d got %b want 00", d, errf[d]);
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    for (int i = 0; i < 4; i++) push({4'(i + 1), 8'(8'h10 + i)});
    idle(60);
    n = n_obs_done[0] - base_done[0];
    checks++;
    if (n !== 4) $display("FAIL burst dut0_count got %0d want 4", n);
    else passes++;
    if (n == 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_done[0][base_done[0] + i][35:32] !== 4'(1 << i))
          $display("FAIL burst order%0d got %b want %b", i,
                   obs_done[0][base_done[0] + i][35:32], 4'(1 << i));
        else passes++;
      end
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (obs_done[0][base_done[0] + i][51:36] - obs_done[0][base_done[0] + i - 1][51:36]
            !== 16'd4)
          $display("FAIL burst spacing%0d got %0d want 4", i,
                   obs_done[0][base_done[0] + i][51:36] - obs_done[0][base_done[0] + i - 1][51:36]);
        else passes++;
      end
    end
    for (int d = 0; d < 2; d++) begin
      checks += 3;
      if (sig_done(d, 1'b1) !== sig_done(d, 1'b0))
        $display("FAIL burst done_log dut%0d got %h want %h", d, sig_done(d, 1'b1), sig_done(d, 1'b0));
      else passes++;
      if (sig_rd(d, 1'b1) !== sig_rd(d, 1'b0))
        $display("FAIL burst rd_log dut%0d got %h want %h", d, sig_rd(d, 1'b1), sig_rd(d, 1'b0));
      else passes++;
      if (errf[d] !== 2'b00) $display("FAIL burst err_flags dut%0d got %b want 00", d, errf[d]);
      else passes++;
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 5; i++) push({4'(i % 4 + 1), 8'(8'h40 + i)});
    checks += 2;
    if (rdy[1] !== 1'b0) $display("FAIL overflow full_ready dut1 got %b want 0", rdy[1]);
    else passes++;
    if (rdy[0] !== (model_cnt(0, int'(cyc) + 1) < int'(DEPTH)))
      $display("FAIL overflow ready dut0 got %b want %b", rdy[0],
               model_cnt(0, int'(cyc) + 1) < int'(DEPTH));
    else passes++;
    push(12'h245);
    checks++;
    if (errf[1][0] !== 1'b1) $display("FAIL overflow err0 dut1 got %b want 1", errf[1][0]);
    else passes++;
    idle(80);
    checks++;
    if (n_obs_done[1] - base_done[1] !== 5)
      $display("FAIL overflow completions dut1 got %0d want 5", n_obs_done[1] - base_done[1]);
    else passes++;
    for (int d = 0; d < 2; d++) begin
      checks += 3;
      if (sig_done(d, 1'b1) !== sig_done(d, 1'b0))
        $display("FAIL overflow done_log dut%0d got %h want %h", d, sig_done(d, 1'b1), sig_done(d, 1'b0));
      else passes++;
      if (sig_rd(d, 1'b1) !== sig_rd(d, 1'b0))
        $display("FAIL overflow rd_log dut%0d got %h want %h", d, sig_rd(d, 1'b1), sig_rd(d, 1'b0));
      else passes++;
      if (errf[d] !== {m_bad[d], m_ovf[d]})
        $display("FAIL overflow err_flags dut%0d got %b want %b", d, errf[d], {m_bad[d], m_ovf[d]});
      else passes++;
    end
  endtask

  task automatic test_bad_number();
    do_reset();
    push(12'h020);
    push(12'h521);
    push(12'h222);
    idle(60);
    for (int d = 0; d < 2; d++) begin
      checks += 5;
      if (n_obs_rd[d] - base_rd[d] !== 3)
        $display("FAIL badnum reads dut%0d got %0d want 3", d, n_obs_rd[d] - base_rd[d]);
      else passes++;
      if (n_obs_done[d] - base_done[d] !== 1)
        $display("FAIL badnum completions dut%0d got %0d want 1", d, n_obs_done[d] - base_done[d]);
      else passes++;
      if (sig_done(d, 1'b1) !== sig_done(d, 1'b0))
        $display("FAIL badnum done_log dut%0d got %h want %h", d, sig_done(d, 1'b1), sig_done(d, 1'b0));
      else passes++;
      if (sig_rd(d, 1'b1) !== sig_rd(d, 1'b0))
        $display("FAIL badnum rd_log dut%0d got %h want %h", d, sig_rd(d, 1'b1), sig_rd(d, 1'b0));
      else passes++;
      if (errf[d] !== 2'b10) $display("FAIL badnum err_flags dut%0d got %b want 10", d, errf[d]);
      else passes++;
    end
  endtask

  task automatic test_push_pop();
    do_reset();
    push(12'h150);
    push(12'h251);
    idle(40);
    for (int d = 0; d < 2; d++) begin
      checks += 4;
      if (n_obs_done[d] - base_done[d] !== 2)
        $display("FAIL pushpop completions dut%0d got %0d want 2", d, n_obs_done[d] - base_done[d]);
      else passes++;
      if (sig_done(d, 1'b1) !== sig_done(d, 1'b0))
        $display("FAIL pushpop done_log dut%0d got %h want %h", d, sig_done(d, 1'b1), sig_done(d, 1'b0));
      else passes++;
      if (sig_rd(d, 1'b1) !== sig_rd(d, 1'b0))
        $display("FAIL pushpop rd_log dut%0d got %h want %h", d, sig_rd(d, 1'b1), sig_rd(d, 1'b0));
      else passes++;
      if (errf[d] !== 2'b00) $display("FAIL pushpop err_flags dut%0d got %b want 00", d, errf[d]);
      else passes++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push(12'h160);
    push(12'h261);
    push(12'h362);
    idle(2);
    do_reset();
    for (int d = 0; d < 2; d++) begin
      checks += 3;
      if (rdy[d] !== 1'b1) $display("FAIL midreset req_ready dut%0d got %b want 1", d, rdy[d]);
      else passes++;
      if (rsp[d] !== 32'h0) $display("FAIL midreset rsp_data dut%0d got %h want 0", d, rsp[d]);
      else passes++;
      if (txn[d] !== 4'h0) $display("FAIL midreset txn_done dut%0d got %h want 0", d, txn[d]);
      else passes++;
    end
    idle(20);
    for (int d = 0; d < 2; d++) begin
      checks += 2;
      if (n_obs_done[d] - base_done[d] !== 0)
        $display("FAIL midreset stale_done dut%0d got %0d want 0", d, n_obs_done[d] - base_done[d]);
      else passes++;
      if (n_obs_rd[d] - base_rd[d] !== 0)
        $display("FAIL midreset stale_read dut%0d got %0d want 0", d, n_obs_rd[d] - base_rd[d]);
      else passes++;
    end
    push(12'h222);
    idle(20);
    for (int d = 0; d < 2; d++) begin
      checks += 2;
      if (sig_done(d, 1'b1) !== sig_done(d, 1'b0))
        $display("FAIL midreset done_log dut%0d got %h want %h", d, sig_done(d, 1'b1), sig_done(d, 1'b0));
      else passes++;
      if (sig_rd(d, 1'b1) !== sig_rd(d, 1'b0))
        $display("FAIL midreset rd_log dut%0d got %h want %h", d, sig_rd(d, 1'b1), sig_rd(d, 1'b0));
      else passes++;
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int t = 0; t < 60; t++) begin
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (rdy[d] !== (model_cnt(d, int'(cyc) + 1) < int'(DEPTH)))
          $display("FAIL random ready dut%0d t%0d got %b want %b", d, t, rdy[d],
                   model_cnt(d, int'(cyc) + 1) < int'(DEPTH));
        else passes++;
      end
      if ($urandom_range(1, 0) == 1) push({4'($urandom_range(5, 0)), 8'($urandom)});
      else step();
    end
    idle(80);
    for (int d = 0; d < 2; d++) begin
      checks += 3;
      if (sig_done(d, 1'b1) !== sig_done(d, 1'b0))
        $display("FAIL random done_log dut%0d got %h want %h", d, sig_done(d, 1'b1), sig_done(d, 1'b0));
      else passes++;
      if (sig_rd(d, 1'b1) !== sig_rd(d, 1'b0))
        $display("FAIL random rd_log dut%0d got %h want %h", d, sig_rd(d, 1'b1), sig_rd(d, 1'b0));
      else passes++;
      if (errf[d] !== {m_bad[d], m_ovf[d]})
        $display("FAIL random err_flags dut%0d got %b want %b", d, errf[d], {m_bad[d], m_ovf[d]});
      else passes++;
    end
  endtask

  initial begin
    req_valid = 1'b0;
    req_word  = 12'h0;
    for (int i = 0; i < 256; i++) tbl[i] = $urandom;
    tbl[8'h3C] = 32'hDEADBEEF;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_bad_number();
    test_push_pop();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
